qsn_pipe_top: RTL and testbench

QSN_PIPE_TOP -- requirements
Module: qsn_pipe_top

---
 rtl/qsn_pkg.sv | 19 +
 rtl/qsn_if.sv | 29 ++
 rtl/qsn_ctrl_dec.sv | 48 ++++
 rtl/qsn_pipe_top.sv | 216 +++++++++++++++++++++
 tb/tb_qsn_pipe_top.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/qsn_pkg.sv
// Shared constants and types for the QSN cyclic-shift pipeline.
// Holds the default geometry and the select encodings used by the decoder and the datapath.
package qsn_pkg;

  localparam int Z_DEF  = 85;
  localparam int QW_DEF = 4;
  localparam int SW_DEF = $clog2(Z_DEF);

  // merge_sel is a bit mask: one bit keeps the right-shift network, one keeps the left.
  localparam int MSEL_W     = 2;
  localparam int MSEL_RIGHT = 0;
  localparam int MSEL_LEFT  = 1;

  typedef enum logic {
    DIR_LSB = 1'b0,
    DIR_MSB = 1'b1
  } dir_e;

endpackage

// File: rtl/qsn_if.sv
// Stream bundle for the QSN pipeline: input beat with shift control, output beat, sticky error.
// The master drives beats and out_ready; the slave is the shifter.
interface qsn_if #(
  parameter int Z  = qsn_pkg::Z_DEF,
  parameter int QW = qsn_pkg::QW_DEF,
  parameter int SW = $clog2(Z)
);

  logic              in_valid;
  logic              in_ready;
  logic [QW*Z-1:0]   in_data;
  logic [SW-1:0]     in_shift;
  logic              in_dir;
  logic              out_valid;
  logic              out_ready;
  logic [QW*Z-1:0]   out_data;
  logic              err_shift;

  modport master (
    output in_valid, in_data, in_shift, in_dir, out_ready,
    input  in_ready, out_valid, out_data, err_shift
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_dir, out_ready,
    output in_ready, out_valid, out_data, err_shift
  );

endinterface

// File: rtl/qsn_ctrl_dec.sv
// Decodes shift/dir into left/right shift amounts and a merge mask; purely combinational.
// Out-of-range shifts fold once by Z (2^SW < 2Z) and raise shift_oor.
module qsn_ctrl_dec
  import qsn_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [SW-1:0]     shift,
  input  logic              dir,
  output logic [SW-1:0]     left_sel,
  output logic [SW-1:0]     right_sel,
  output logic [MSEL_W-1:0] merge_sel,
  output logic              shift_oor
);

  localparam logic [SW:0] Z_EXT = Z[SW:0];

  logic [SW:0]   sh_ext;
  logic [SW-1:0] s_eff;
  logic [SW-1:0] s_cmp;

  always_comb begin
    sh_ext    = {1'b0, shift};
    shift_oor = (sh_ext >= Z_EXT);
    s_eff     = shift_oor ? SW'(sh_ext - Z_EXT) : shift;
    s_cmp     = SW'(Z_EXT - {1'b0, s_eff});
    left_sel  = '0;
    right_sel = '0;
    merge_sel = '0;
    // s = 0 would need a shift of Z on the complementary side; keep one network only.
    if (s_eff == '0) begin
      if (dir == DIR_MSB) merge_sel[MSEL_LEFT]  = 1'b1;
      else                merge_sel[MSEL_RIGHT] = 1'b1;
    end else begin
      merge_sel[MSEL_LEFT]  = 1'b1;
      merge_sel[MSEL_RIGHT] = 1'b1;
      if (dir == DIR_MSB) begin
        left_sel  = s_eff;
        right_sel = s_cmp;
      end else begin
        left_sel  = s_cmp;
        right_sel = s_eff;
      end
    end
  end

endmodule

// File: rtl/qsn_pipe_top.sv
// QSN cyclic shifter over QW planes of Z bits; latency 2 (3 with QSN_MID_PIPE_EN), one beat/cycle.
// Valid/ready backpressure: every stage holds while its successor is full and stalled.
module qsn_pipe_core
  import qsn_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int QW = QW_DEF,
  parameter int SW = $clog2(Z)
) (
  input  logic  sys_clk,
  input  logic  rstn,
  qsn_if.slave  bus
);

  localparam int DW = QW * Z;

  logic [SW-1:0]     dec_lsel, dec_rsel;
  logic [MSEL_W-1:0] dec_msel;
  logic              dec_oor;

  qsn_ctrl_dec #(.Z(Z), .SW(SW)) u_dec (
    .shift     (bus.in_shift),
    .dir       (bus.in_dir),
    .left_sel  (dec_lsel),
    .right_sel (dec_rsel),
    .merge_sel (dec_msel),
    .shift_oor (dec_oor)
  );

  logic              s1_vld_q, s1_vld_d;
  logic [DW-1:0]     s1_dat_q, s1_dat_d;
  logic [SW-1:0]     s1_lsel_q, s1_lsel_d;
  logic [SW-1:0]     s1_rsel_q, s1_rsel_d;
  logic [MSEL_W-1:0] s1_msel_q, s1_msel_d;
  logic              err_q, err_d;
  logic              s2_vld_q, s2_vld_d;
  logic [DW-1:0]     s2_dat_q, s2_dat_d;

  logic [DW-1:0]     shl_dat, shr_dat;
  logic              mg_vld;
  logic [DW-1:0]     mg_l, mg_r, merged;
  logic [MSEL_W-1:0] mg_msel;
  logic              s2_en, s1_adv, acc;

  function automatic logic [Z-1:0] shl_net(input logic [Z-1:0] x, input logic [SW-1:0] n);
    logic [Z-1:0] y;
    y = x;
    for (int k = 0; k < SW; k++) if (n[k]) y = y << (1 << k);
    return y;
  endfunction

  function automatic logic [Z-1:0] shr_net(input logic [Z-1:0] x, input logic [SW-1:0] n);
    logic [Z-1:0] y;
    y = x;
    for (int k = 0; k < SW; k++) if (n[k]) y = y >> (1 << k);
    return y;
  endfunction

  always_comb begin
    shl_dat = '0;
    shr_dat = '0;
    for (int q = 0; q < QW; q++) begin
      shl_dat[q*Z +: Z] = shl_net(s1_dat_q[q*Z +: Z], s1_lsel_q);
      shr_dat[q*Z +: Z] = shr_net(s1_dat_q[q*Z +: Z], s1_rsel_q);
    end
  end

  assign s2_en = !s2_vld_q || bus.out_ready;

`ifdef QSN_MID_PIPE_EN
  logic              m_vld_q, m_vld_d;
  logic [DW-1:0]     m_l_q, m_l_d;
  logic [DW-1:0]     m_r_q, m_r_d;
  logic [MSEL_W-1:0] m_msel_q, m_msel_d;
  logic              m_en;

  assign m_en    = !m_vld_q || s2_en;
  assign s1_adv  = m_en;
  assign mg_vld  = m_vld_q;
  assign mg_l    = m_l_q;
  assign mg_r    = m_r_q;
  assign mg_msel = m_msel_q;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_l_d    = m_l_q;
    m_r_d    = m_r_q;
    m_msel_d = m_msel_q;
    if (m_en) begin
      m_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        m_l_d    = shl_dat;
        m_r_d    = shr_dat;
        m_msel_d = s1_msel_q;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      m_vld_q  <= 1'b0;
      m_l_q    <= '0;
      m_r_q    <= '0;
      m_msel_q <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_l_q    <= m_l_d;
      m_r_q    <= m_r_d;
      m_msel_q <= m_msel_d;
    end
  end
`else
  assign s1_adv  = s2_en;
  assign mg_vld  = s1_vld_q;
  assign mg_l    = shl_dat;
  assign mg_r    = shr_dat;
  assign mg_msel = s1_msel_q;
`endif

  assign merged = ({DW{mg_msel[MSEL_RIGHT]}} & mg_r) | ({DW{mg_msel[MSEL_LEFT]}} & mg_l);

  // Held low during reset even though the stages already read empty.
  assign bus.in_ready = !rstn && (!s1_vld_q || s1_adv);
  assign acc          = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_dat_d  = s1_dat_q;
    s1_lsel_d = s1_lsel_q;
    s1_rsel_d = s1_rsel_q;
    s1_msel_d = s1_msel_q;
    err_d     = err_q | (acc & dec_oor);
    if (!s1_vld_q || s1_adv) begin
      s1_vld_d = acc;
      if (acc) begin
        s1_dat_d  = bus.in_data;
        s1_lsel_d = dec_lsel;
        s1_rsel_d = dec_rsel;
        s1_msel_d = dec_msel;
      end
    end
    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    if (s2_en) begin
      s2_vld_d = mg_vld;
      if (mg_vld) s2_dat_d = merged;
    end
  end

  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_lsel_q <= '0;
      s1_rsel_q <= '0;
      s1_msel_q <= '0;
      err_q     <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      s1_lsel_q <= s1_lsel_d;
      s1_rsel_q <= s1_rsel_d;
      s1_msel_q <= s1_msel_d;
      err_q     <= err_d;
      s2_vld_q  <= s2_vld_d;
      s2_dat_q  <= s2_dat_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_dat_q;
  assign bus.err_shift = err_q;

endmodule

module qsn_pipe_top
  import qsn_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int QW = QW_DEF,
  parameter int SW = $clog2(Z)
) (
  input  logic            sys_clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [QW*Z-1:0] in_data,
  input  logic [SW-1:0]   in_shift,
  input  logic            in_dir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW*Z-1:0] out_data,
  output logic            err_shift
);

  qsn_if #(.Z(Z), .QW(QW), .SW(SW)) bus ();

  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign bus.in_shift  = in_shift;
  assign bus.in_dir    = in_dir;
  assign bus.out_ready = out_ready;
  assign in_ready      = bus.in_ready;
  assign out_valid     = bus.out_valid;
  assign out_data      = bus.out_data;
  assign err_shift     = bus.err_shift;

  qsn_pipe_core #(.Z(Z), .QW(QW), .SW(SW)) u_core (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

endmodule

// File: tb/tb_qsn_pipe_top.sv
// Directed bench for qsn_pipe_top: rotation vectors, sticky error, backpressure and mid-flight reset.
// Latency expectation follows QSN_MID_PIPE_EN.
module tb_qsn_pipe_top;
  import qsn_pkg::*;

  localparam int Z  = 85;
  localparam int QW = 4;
  localparam int SW = $clog2(Z);
  localparam int DW = QW * Z;
`ifdef QSN_MID_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic sys_clk;
  logic rstn;
  int   tests;
  int   fails;

  qsn_if #(.Z(Z), .QW(QW), .SW(SW)) tb_if ();

  qsn_pipe_top #(.Z(Z), .QW(QW), .SW(SW)) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .in_valid  (tb_if.in_valid),
    .in_ready  (tb_if.in_ready),
    .in_data   (tb_if.in_data),
    .in_shift  (tb_if.in_shift),
    .in_dir    (tb_if.in_dir),
    .out_valid (tb_if.out_valid),
    .out_ready (tb_if.out_ready),
    .out_data  (tb_if.out_data),
    .err_shift (tb_if.err_shift)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] rot(input logic [DW-1:0] d, input int sh, input bit dir);
    logic [DW-1:0] r;
    int s;
    s = (sh >= Z) ? sh - Z : sh;
    r = '0;
    for (int q = 0; q < QW; q++)
      for (int j = 0; j < Z; j++)
        r[q*Z + j] = dir ? d[q*Z + ((j - s + Z) % Z)] : d[q*Z + ((j + s) % Z)];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Called just after a clock edge with the pipe empty and out_ready high.
  task automatic send_one(input string tag, input logic [DW-1:0] d, input int sh, input bit dir,
                          input logic [DW-1:0] want);
    tb_if.in_valid = 1'b1;
    tb_if.in_data  = d;
    tb_if.in_shift = SW'(sh);
    tb_if.in_dir   = dir;
    #1;
    check({tag, "_rdy"}, DW'(tb_if.in_ready), DW'(1'b1));
    tick();
    tb_if.in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      check({tag, "_early"}, DW'(tb_if.out_valid), DW'(1'b0));
      tick();
    end
    check({tag, "_vld"}, DW'(tb_if.out_valid), DW'(1'b1));
    check({tag, "_dat"}, tb_if.out_data, want);
    tick();
  endtask

  logic [DW-1:0] d, want;
  logic [DW-1:0] vec [10];
  logic [DW-1:0] expd[10];
  logic [DW-1:0] prev_dat;
  bit            prev_stall;
  int            sh_v[10];
  bit            dir_v[10];
  int            sent, rcv;
  bit            pat[4];

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b1;
    tb_if.in_valid  = 1'b0;
    tb_if.in_data   = '0;
    tb_if.in_shift  = '0;
    tb_if.in_dir    = 1'b0;
    tb_if.out_ready = 1'b1;
    #2;
    check("rst_out_valid", DW'(tb_if.out_valid), DW'(1'b0));
    check("rst_out_data",  tb_if.out_data, '0);
    check("rst_err",       DW'(tb_if.err_shift), DW'(1'b0));
    check("rst_in_ready",  DW'(tb_if.in_ready), DW'(1'b0));
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("rel_in_ready", DW'(tb_if.in_ready), DW'(1'b1));
    tick();

    // plane0 bit0, shift 1 toward LSB -> bit 84
    d = '0; d[0] = 1'b1;
    want = '0; want[84] = 1'b1;
    send_one("rot1_lsb", d, 1, 1'b0, want);
    check("rot1_err", DW'(tb_if.err_shift), DW'(1'b0));

    // shift 90 folds to 5: plane0 bit10 -> 5, plane3 bit2 -> 82
    d = '0; d[10] = 1'b1; d[3*Z + 2] = 1'b1;
    want = '0; want[5] = 1'b1; want[3*Z + 82] = 1'b1;
    send_one("sh90", d, 90, 1'b0, want);
    check("sh90_err", DW'(tb_if.err_shift), DW'(1'b1));
    send_one("sh5", d, 5, 1'b0, want);
    check("sh5_err_sticky", DW'(tb_if.err_shift), DW'(1'b1));

    // plane1 bit83 toward MSB by 3 wraps to bit1
    d = '0; d[Z + 83] = 1'b1;
    want = '0; want[Z + 1] = 1'b1;
    send_one("wrap_msb", d, 3, 1'b1, want);

    d = rnd_data();
    send_one("zero_msb", d, 0, 1'b1, d);
    d = rnd_data();
    send_one("zero_lsb", d, 0, 1'b0, d);
    d = rnd_data();
    send_one("sh85_pass", d, 85, 1'b0, d);
    d = rnd_data();
    send_one("sh84_msb", d, 84, 1'b1, rot(d, 84, 1'b1));
    d = rnd_data();
    send_one("sh127_lsb", d, 127, 1'b0, rot(d, 127, 1'b0));
    check("err_still_set", DW'(tb_if.err_shift), DW'(1'b1));

    // 10 back-to-back beats, out_ready pattern 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec[i]   = rnd_data();
      sh_v[i]  = int'($urandom_range(0, 127));
      dir_v[i] = 1'($urandom_range(0, 1));
      expd[i]  = rot(vec[i], sh_v[i], dir_v[i]);
    end
    sent = 0;
    rcv = 0;
    prev_stall = 1'b0;
    prev_dat = '0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      tb_if.out_ready = pat[cyc % 4];
      tb_if.in_valid  = (sent < 10);
      tb_if.in_data   = vec[sent % 10];
      tb_if.in_shift  = SW'(sh_v[sent % 10]);
      tb_if.in_dir    = dir_v[sent % 10];
      #1;
      if (prev_stall) begin
        check("stall_vld", DW'(tb_if.out_valid), DW'(1'b1));
        check("stall_dat", tb_if.out_data, prev_dat);
      end
      if (tb_if.out_valid && tb_if.out_ready) begin
        check($sformatf("b2b_dat%0d", rcv), tb_if.out_data, expd[rcv]);
        rcv++;
      end
      if (tb_if.in_valid && tb_if.in_ready) sent++;
      prev_stall = tb_if.out_valid && !tb_if.out_ready;
      prev_dat   = tb_if.out_data;
      tick();
    end
    tb_if.in_valid  = 1'b0;
    tb_if.out_ready = 1'b1;
    check("b2b_count", DW'(rcv), DW'(10));
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b2b_no_dup", DW'(tb_if.out_valid), DW'(1'b0));
      tick();
    end

    // two beats in flight, then asynchronous reset
    tb_if.out_ready = 1'b0;
    tb_if.in_valid  = 1'b1;
    tb_if.in_data   = rnd_data();
    tb_if.in_shift  = SW'(100);
    tb_if.in_dir    = 1'b0;
    tick();
    tb_if.in_data   = rnd_data();
    tick();
    tb_if.in_valid  = 1'b0;
    for (int i = 2; i < LAT; i++) tick();
    check("flight_vld", DW'(tb_if.out_valid), DW'(1'b1));
    rstn = 1'b1;
    #1;
    check("mid_rst_vld",   DW'(tb_if.out_valid), DW'(1'b0));
    check("mid_rst_dat",   tb_if.out_data, '0);
    check("mid_rst_err",   DW'(tb_if.err_shift), DW'(1'b0));
    check("mid_rst_ready", DW'(tb_if.in_ready), DW'(1'b0));
    tick();
    tick();
    rstn = 1'b0;
    tb_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("no_stale", DW'(tb_if.out_valid), DW'(1'b0));
      tick();
    end

    d = rnd_data();
    send_one("post_rst_zero", d, 0, 1'b0, d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
